// File: rtl/sfll_hd_lock_pipe_pkg.sv
// Shared types and helpers for the SFLL-HD restore wrapper and its monitors.
package lock_pkg;

  typedef enum logic [1:0] {
    KEY_EMPTY   = 2'd0,
    KEY_LOADING = 2'd1,
    KEY_ARMED   = 2'd2
  } key_state_e;

  function automatic int hd_width(input int wkey);
    return $clog2(wkey + 1);
  endfunction

endpackage

// File: rtl/sfll_hd_lock_pipe_dut.sv
// Behavioural stand-in for the perturbed netlist: reduction XOR of all inputs.
module DUT #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);

  assign out = ^in;

endmodule

// File: rtl/sfll_hd_lock_pipe_popcount.sv
// Combinational population count, shared with the HD-attack monitors.
module popcount
  import lock_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]            i_vec,
  output logic [$clog2(W+1)-1:0]  o_cnt
);

  localparam int CW = hd_width(W);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + CW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/sfll_hd_lock_pipe.sv
// SFLL-HD restore wrapper: serial key load plus a 2-stage valid-qualified
// pipeline that flips DUT.out when popcount(protected_in ^ key) == HD.
module sfll_hd_lock_pipe
  import lock_pkg::*;
#(
  parameter int WKEY   = 32,
  parameter int WINPUT = 32,
  parameter int HD     = 0
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  input  logic [((WINPUT > WKEY) ? (WINPUT - WKEY) : 1) - 1:0] other_in,
  input  logic [WKEY-1:0]                                      protected_in,
  input  logic                                                 key_load,
  input  logic                                                 key_bit,
  input  logic                                                 key_bit_valid,
  output logic                                                 key_ready,
  output logic                                                 out_valid,
  output logic                                                 out
);

  localparam int CW = hd_width(WKEY);

  if (HD > WKEY || HD < 0) begin : g_bad_hd
    $error("sfll_hd_lock_pipe: HD=%0d must lie in 0..WKEY=%0d", HD, WKEY);
  end
  if (WINPUT < WKEY || WKEY < 1) begin : g_bad_width
    $error("sfll_hd_lock_pipe: need WINPUT >= WKEY >= 1");
  end

  key_state_e        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WKEY-1:0]   r_key;
  logic [WINPUT-1:0] w_in;

  if (WINPUT > WKEY) begin : g_other
    assign w_in = {other_in, protected_in};
  end else begin : g_no_other
    logic w_unused_other;
    assign w_unused_other = ^other_in;
    assign w_in           = protected_in;
  end

  // key_load has priority over a coincident key bit, which is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= KEY_EMPTY;
      r_cnt   <= '0;
      r_key   <= '0;
    end else if (key_load) begin
      r_state <= KEY_LOADING;
      r_cnt   <= '0;
    end else if (r_state == KEY_LOADING && key_bit_valid) begin
      for (int i = 0; i < WKEY; i++) begin
        if (r_cnt == CW'(i)) r_key[i] <= key_bit;
      end
      if (r_cnt == CW'(WKEY - 1)) r_state <= KEY_ARMED;
      else                        r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign key_ready = (r_state == KEY_ARMED);

  // ---- stage 1: snapshot sample, key difference and arm state ----
  logic [WINPUT-1:0] r_in_p1;
  logic [WKEY-1:0]   r_diff_p1;
  logic              r_arm_p1;
  logic              r_vld_p1;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_in_p1   <= w_in;
      r_diff_p1 <= protected_in ^ r_key;
      r_arm_p1  <= key_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= in_valid;
  end

  // ---- stage 2: perturbed function, distance test, restore ----
  logic          w_f;
  logic [CW-1:0] w_hd;
  logic          w_restore;
  logic          r_out_p2;
  logic          r_vld_p2;

  DUT #(.WIDTH(WINPUT)) u_dut (
    .in  (r_in_p1),
    .out (w_f)
  );

  popcount #(.W(WKEY)) u_popcount (
    .i_vec (r_diff_p1),
    .o_cnt (w_hd)
  );

  assign w_restore = r_arm_p1 & (w_hd == CW'(HD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p2 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_out_p2 <= w_f ^ w_restore;
    end
  end

  assign out       = r_out_p2;
  assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_sfll_hd_lock_pipe.sv
// Randomised bench for sfll_hd_lock_pipe: SFLL-HD (4/6/1) and TTLock (4/4/0) instances.
module tb_sfll_hd_lock_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_iv, a_kl, a_kb, a_kbv, a_kr, a_ov, a_out;
  logic [1:0] a_oth;
  logic [3:0] a_prot;
  logic b_iv, b_kl, b_kb, b_kbv, b_kr, b_ov, b_out;
  logic b_oth;
  logic [3:0] b_prot;

  sfll_hd_lock_pipe #(.WKEY(4), .WINPUT(6), .HD(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .other_in(a_oth), .protected_in(a_prot),
    .key_load(a_kl), .key_bit(a_kb), .key_bit_valid(a_kbv),
    .key_ready(a_kr), .out_valid(a_ov), .out(a_out)
  );

  sfll_hd_lock_pipe #(.WKEY(4), .WINPUT(4), .HD(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .other_in(b_oth), .protected_in(b_prot),
    .key_load(b_kl), .key_bit(b_kb), .key_bit_valid(b_kbv),
    .key_ready(b_kr), .out_valid(b_ov), .out(b_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of instance A: key register, load progress, and the
  // expected result of each accepted sample travelling toward the output.
  logic [3:0] m_key;
  int         m_cnt;
  bit         m_loading, m_armed;
  bit         s1_v;
  logic       s1_val;
  logic       e_vld, e_out;

  function automatic logic ref_out(input logic [1:0] oth, input logic [3:0] prot,
                                   input logic [3:0] key, input bit armed);
    return (^{oth, prot}) ^ (armed && ($countones(prot ^ key) == 1));
  endfunction

  task automatic tick();
    if (rst) begin
      m_key = 4'd0; m_cnt = 0; m_loading = 0; m_armed = 0;
      s1_v = 0; e_vld = 1'b0; e_out = 1'b0;
    end else begin
      if (s1_v) e_out = s1_val;
      e_vld = s1_v;
      if (a_iv) s1_val = ref_out(a_oth, a_prot, m_key, m_armed);
      s1_v = a_iv;
      if (a_kl) begin
        m_loading = 1; m_armed = 0; m_cnt = 0;
      end else if (m_loading && a_kbv) begin
        m_key[m_cnt] = a_kb;
        if (m_cnt == 3) begin m_loading = 0; m_armed = 1; end
        else m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_out !== 1'b0 || a_kr !== 1'b0) begin
      errors++;
      $display("FAIL reset_a got vld=%b out=%b rdy=%b required 0 0 0", a_ov, a_out, a_kr);
    end
    checks++;
    if (b_ov !== 1'b0 || b_out !== 1'b0 || b_kr !== 1'b0) begin
      errors++;
      $display("FAIL reset_b got vld=%b out=%b rdy=%b required 0 0 0", b_ov, b_out, b_kr);
    end
  endtask

  task automatic test_no_key();
    a_iv = 1'b1; a_prot = 4'b0001; a_oth = 2'b00;
    tick();
    a_iv = 1'b0;
    checks++;
    if (a_ov !== 1'b0) begin
      errors++; $display("FAIL nokey_early got vld=%b required 0", a_ov);
    end
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b1 || a_kr !== 1'b0) begin
      errors++;
      $display("FAIL nokey_out got vld=%b out=%b rdy=%b required 1 1 0", a_ov, a_out, a_kr);
    end
    tick();
    checks++;
    if (a_ov !== 1'b0 || a_out !== 1'b1) begin
      errors++; $display("FAIL nokey_hold got vld=%b out=%b required 0 1", a_ov, a_out);
    end
  endtask

  task automatic test_key_load();
    logic [3:0] k;
    k = 4'b1010;
    a_kl = 1'b1;
    tick();
    a_kl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_kbv = 1'b1; a_kb = k[i];
      if (i == 3) begin
        a_iv = 1'b1; a_prot = 4'b1011; a_oth = 2'b00;
        checks++;
        if (a_kr !== 1'b0) begin
          errors++; $display("FAIL key_early_ready got %b required 0", a_kr);
        end
      end
      tick();
      a_kbv = 1'b0; a_iv = 1'b0;
      if (i < 3) begin tick(); tick(); end
    end
    checks++;
    if (a_kr !== 1'b1) begin
      errors++; $display("FAIL key_ready got %b required 1", a_kr);
    end
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b1) begin
      errors++; $display("FAIL key_same_edge got vld=%b out=%b required 1 1", a_ov, a_out);
    end
    a_iv = 1'b1; a_prot = 4'b1011;
    tick();
    a_prot = 4'b1010;
    tick();
    a_iv = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b0) begin
      errors++; $display("FAIL restore_hd1 got vld=%b out=%b required 1 0", a_ov, a_out);
    end
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b0) begin
      errors++; $display("FAIL restore_hd0 got vld=%b out=%b required 1 0", a_ov, a_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pats [4];
    logic [1:0] oths [4];
    logic [3:0] flips;
    int seen;
    pats = '{4'b1011, 4'b1001, 4'b1110, 4'b1010};
    flips = 4'b0000;
    seen = 0;
    for (int i = 0; i < 4; i++) oths[i] = 2'($urandom);
    for (int c = 0; c < 7; c++) begin
      a_iv = (c < 4);
      if (c < 4) begin a_prot = pats[c]; a_oth = oths[c]; end
      tick();
      checks++;
      if (a_ov !== e_vld || (e_vld && a_out !== e_out)) begin
        errors++;
        $display("FAIL b2b_cycle%0d got vld=%b out=%b required %b %b", c, a_ov, a_out, e_vld, e_out);
      end
      if (a_ov === 1'b1 && seen < 4) begin
        flips[seen] = a_out ^ (^{oths[seen], pats[seen]});
        seen++;
      end
    end
    a_iv = 1'b0;
    checks++;
    if (seen !== 4 || flips !== 4'b0101) begin
      errors++; $display("FAIL b2b_flips got n=%0d flips=%b required 4 0101", seen, flips);
    end
  endtask

  task automatic test_reload();
    logic [3:0] k;
    k = 4'b0101;
    for (int c = 0; c < 24; c++) begin
      a_iv = 1'($urandom); a_prot = 4'($urandom); a_oth = 2'($urandom);
      a_kl = (c == 2); a_kbv = 1'b0; a_kb = 1'b0;
      if (c == 3) begin a_kl = 1'b1; a_kbv = 1'b1; a_kb = 1'b1; end
      if (c >= 6 && c <= 9) begin a_kbv = 1'b1; a_kb = k[c-6]; end
      if (c >= 4 && c <= 5) begin a_kbv = 1'($urandom); a_kb = 1'($urandom); end
      if (c == 5) a_kbv = 1'b0;
      if (c == 4) a_kbv = 1'b0;
      tick();
      checks++;
      if (a_ov !== e_vld || (e_vld && a_out !== e_out) || a_kr !== m_armed) begin
        errors++;
        $display("FAIL reload_cycle%0d got vld=%b out=%b rdy=%b required %b %b %b",
                 c, a_ov, a_out, a_kr, e_vld, e_out, m_armed);
      end
    end
    a_iv = 1'b0; a_kl = 1'b0; a_kbv = 1'b0;
    checks++;
    if (m_key !== 4'b0101 || a_kr !== 1'b1) begin
      errors++; $display("FAIL reload_key model=%b rdy=%b required 0101 1", m_key, a_kr);
    end
    a_iv = 1'b1; a_prot = 4'b0100; a_oth = 2'b00;
    tick();
    a_iv = 1'b0;
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b0) begin
      errors++; $display("FAIL reload_restore got vld=%b out=%b required 1 0", a_ov, a_out);
    end
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 60; c++) begin
      a_iv = ($urandom_range(3) != 0); a_prot = 4'($urandom); a_oth = 2'($urandom);
      a_kl = ($urandom_range(15) == 0); a_kbv = 1'($urandom); a_kb = 1'($urandom);
      tick();
      checks++;
      if (a_ov !== e_vld || (e_vld && a_out !== e_out) || a_kr !== m_armed) begin
        errors++;
        $display("FAIL rand_cycle%0d got vld=%b out=%b rdy=%b required %b %b %b",
                 c, a_ov, a_out, a_kr, e_vld, e_out, m_armed);
      end
    end
    a_iv = 1'b0; a_kl = 1'b0; a_kbv = 1'b0;
  endtask

  task automatic test_rst_mid();
    a_kl = 1'b1;
    tick();
    a_kl = 1'b0; a_kbv = 1'b1; a_kb = 1'b1;
    tick();
    a_kbv = 1'b0; a_iv = 1'b1; a_prot = 4'($urandom); a_oth = 2'($urandom);
    tick();
    a_iv = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_kr !== 1'b0) begin
      errors++; $display("FAIL rst_mid got vld=%b rdy=%b required 0 0", a_ov, a_kr);
    end
    tick();
    checks++;
    if (a_ov !== 1'b0) begin
      errors++; $display("FAIL rst_mid_killed got vld=%b required 0", a_ov);
    end
    a_iv = 1'b1; a_prot = 4'b1011; a_oth = 2'b00;
    tick();
    a_iv = 1'b0;
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_out !== 1'b1) begin
      errors++; $display("FAIL rst_after got vld=%b out=%b required 1 1", a_ov, a_out);
    end
  endtask

  task automatic test_ttlock();
    logic [3:0] k;
    logic       exp;
    k = 4'b0110;
    b_kl = 1'b1;
    tick();
    b_kl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_kbv = 1'b1; b_kb = k[i];
      tick();
    end
    b_kbv = 1'b0;
    checks++;
    if (b_kr !== 1'b1) begin
      errors++; $display("FAIL tt_ready got %b required 1", b_kr);
    end
    for (int p = 0; p < 16; p++) begin
      b_iv = 1'b1; b_prot = 4'(p); b_oth = 1'($urandom);
      tick();
      b_iv = 1'b0;
      tick();
      exp = (^b_prot) ^ (b_prot == k);
      checks++;
      if (b_ov !== 1'b1 || b_out !== exp) begin
        errors++;
        $display("FAIL tt_pat%0d got vld=%b out=%b required 1 %b", p, b_ov, b_out, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_kl = 1'b0; a_kb = 1'b0; a_kbv = 1'b0; a_oth = 2'b00; a_prot = 4'd0;
    b_iv = 1'b0; b_kl = 1'b0; b_kb = 1'b0; b_kbv = 1'b0; b_oth = 1'b0; b_prot = 4'd0;
    test_reset();
    test_no_key();
    test_key_load();
    test_back_to_back();
    test_reload();
    test_random_stream();
    test_rst_mid();
    test_ttlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
